// File: rtl/mem_byte_ctrl.sv
// mem_byte_ctrl: word-to-byte bridge between the cache mem port
// and an 8-bit request/acknowledge external memory bus.
module mem_byte_ctrl #(
  parameter int unsigned TIMEOUT   = 0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  rw_flag,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_mask,
  output logic [31:0] r_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  localparam logic [CNT_WIDTH-1:0] WD_LAST =
    CNT_WIDTH'(TIMEOUT - 1);

  logic [0:0]           state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [31:0]          r_data_q, r_data_d;
  logic                 ext_req_q, ext_req_d;
  logic                 ext_we_q, ext_we_d;
  logic [31:0]          ext_addr_q, ext_addr_d;
  logic [7:0]           ext_wdata_q, ext_wdata_d;
  logic [CNT_WIDTH-1:0] wd_q, wd_d;
  logic [3:0]           rem_q, rem_d;
  logic                 rd_q, rd_d;
  logic [29:0]          word_q, word_d;
  logic [31:0]          wdat_q, wdat_d;
  logic [31:0]          rbuf_q, rbuf_d;

  logic [3:0]  eff_mask;
  logic [1:0]  fidx;
  logic [1:0]  idx;
  logic [3:0]  rem_n;
  logic [1:0]  nidx;
  logic [31:0] rbuf_n;
  logic        addr_unused;

  assign addr_unused = ^addr[1:0];

  function automatic logic [1:0] first_idx(
    input logic [3:0] m
  );
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    r_data_d    = r_data_q;
    ext_req_d   = ext_req_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    wd_d        = wd_q;
    rem_d       = rem_q;
    rd_d        = rd_q;
    word_d      = word_q;
    wdat_d      = wdat_q;
    rbuf_d      = rbuf_q;

    // a read always needs all four bytes and wins over a write
    eff_mask = rw_flag[0] ? 4'hF : w_mask;
    fidx     = first_idx(eff_mask);
    idx      = ext_addr_q[1:0];
    rem_n    = rem_q & ~(4'b0001 << idx);
    nidx     = first_idx(rem_n);
    rbuf_n   = rbuf_q;
    rbuf_n[{idx, 3'b000} +: 8] = ext_rdata;

    case (state_q)
      S_IDLE: begin
        if (rw_flag != 2'b00) begin
          rd_d   = rw_flag[0];
          word_d = addr[31:2];
          wdat_d = w_data;
          rem_d  = eff_mask;
          wd_d   = '0;
          if (eff_mask == 4'h0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_XFER;
            busy_d      = 1'b1;
            ext_req_d   = 1'b1;
            ext_we_d    = ~rw_flag[0];
            ext_addr_d  = {addr[31:2], fidx};
            ext_wdata_d = w_data[{fidx, 3'b000} +: 8];
          end
        end
      end
      S_XFER: begin
        if (ext_ack) begin
          rbuf_d = rbuf_n;
          rem_d  = rem_n;
          wd_d   = '0;
          if (rem_n == 4'h0) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            ext_req_d = 1'b0;
            done_d    = 1'b1;
            if (rd_q) r_data_d = rbuf_n;
          end else begin
            ext_addr_d  = {word_q, nidx};
            ext_wdata_d = wdat_q[{nidx, 3'b000} +: 8];
          end
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + CNT_WIDTH'(1);
          if (wd_q == WD_LAST) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            ext_req_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            if (rd_q) r_data_d = 32'hFFFF_FFFF;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      r_data_q    <= '0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      wd_q        <= '0;
      rem_q       <= '0;
      rd_q        <= 1'b0;
      word_q      <= '0;
      wdat_q      <= '0;
      rbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      r_data_q    <= r_data_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      wd_q        <= wd_d;
      rem_q       <= rem_d;
      rd_q        <= rd_d;
      word_q      <= word_d;
      wdat_q      <= wdat_d;
      rbuf_q      <= rbuf_d;
    end
  end

  assign r_data    = r_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ext_req   = ext_req_q;
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;

endmodule
